// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard sources into
// per-register hold/bubble controls and owns the multi-cycle divider counter.
module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic conflict_stall,
  input  logic div_start,
  input  logic inst_busy,
  input  logic data_busy,
  input  logic exc_mem,
  output logic stall_if,
  output logic stall_id,
  output logic stall_ex,
  output logic stall_mem,
  output logic flush_id,
  output logic flush_ex,
  output logic flush_mem,
  output logic flush_wb,
  output logic div_busy,
  output logic div_done
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e       div_state_q, div_state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             exc_pend_q, exc_pend_d;
  logic             kill_pend_q, kill_pend_d;

  logic p0_c, p1_c, p2_c, kill_flush_c;

  // Hazard source decode in priority order
  always_comb begin
    p0_c         = (exc_mem | exc_pend_q) & ~data_busy;
    p1_c         = data_busy;
    p2_c         = ~p0_c & ~p1_c &
                   (((div_state_q == DIV_IDLE) & div_start) | (div_state_q == DIV_BUSY));
    kill_flush_c = kill_pend_q & ~inst_busy & ~p0_c & ~p1_c & ~p2_c;
  end

  // Next-state: divider FSM, counter, pending exception and fetch-kill flags
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    exc_pend_d  = exc_pend_q;
    kill_pend_d = kill_pend_q;

    case (div_state_q)
      DIV_IDLE: begin
        if (div_start && !p0_c && !p1_c) begin
          div_state_d = DIV_BUSY;
          div_cnt_d   = CNT_W'(1);
        end
      end
      DIV_BUSY: begin
        // Counts through data stalls; the start cycle already counted as one
        if (div_cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          div_state_d = DIV_DONE;
          div_cnt_d   = '0;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      DIV_DONE: begin
        if (!p1_c) begin
          div_state_d = DIV_IDLE;
        end
      end
      default: begin
        div_state_d = DIV_IDLE;
        div_cnt_d   = '0;
      end
    endcase

    if (p0_c) begin
      div_state_d = DIV_IDLE;
      div_cnt_d   = '0;
      exc_pend_d  = 1'b0;
    end else if (exc_mem && data_busy) begin
      exc_pend_d = 1'b1;
    end

    // A flush with a fetch in flight must discard that fetch when it lands
    if (p0_c && inst_busy) begin
      kill_pend_d = 1'b1;
    end else if (kill_pend_q && !inst_busy && !p1_c && !p2_c) begin
      kill_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      exc_pend_q  <= 1'b0;
      kill_pend_q <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      exc_pend_q  <= exc_pend_d;
      kill_pend_q <= kill_pend_d;
    end
  end

  // Zero-latency outputs; only the highest active source drives them
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    div_busy  = 1'b0;
    div_done  = 1'b0;

    if (!rst) begin
      div_done = (div_state_q == DIV_DONE) & ~p0_c;
      if (p0_c) begin
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (p1_c) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (p2_c) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
        div_busy  = 1'b1;
      end else if (kill_flush_c) begin
        flush_id = 1'b1;
      end else if (inst_busy) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end else if (conflict_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: vector table plus multi-cycle divider,
// flush and reset sequences with hand-computed expected outputs.
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  logic conflict_stall, div_start, inst_busy, data_busy, exc_mem;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb;
  logic div_busy, div_done;

  int total;
  int bad;

  // Output vector bit positions: {stall_if..stall_mem, flush_id..flush_wb, div_busy, div_done}
  localparam logic [9:0] S_IF   = 10'b10_0000_0000;
  localparam logic [9:0] S_ID   = 10'b01_0000_0000;
  localparam logic [9:0] S_EX   = 10'b00_1000_0000;
  localparam logic [9:0] S_MEM  = 10'b00_0100_0000;
  localparam logic [9:0] F_ID   = 10'b00_0010_0000;
  localparam logic [9:0] F_EX   = 10'b00_0001_0000;
  localparam logic [9:0] F_MEM  = 10'b00_0000_1000;
  localparam logic [9:0] F_WB   = 10'b00_0000_0100;
  localparam logic [9:0] D_BUSY = 10'b00_0000_0010;
  localparam logic [9:0] D_DONE = 10'b00_0000_0001;

  localparam logic [9:0] E_NONE = 10'b0;
  localparam logic [9:0] E_CONF = S_IF | S_ID | F_EX;
  localparam logic [9:0] E_INST = S_IF | F_ID;
  localparam logic [9:0] E_DATA = S_IF | S_ID | S_EX | S_MEM | F_WB;
  localparam logic [9:0] E_EXC  = F_ID | F_EX | F_MEM | F_WB;
  localparam logic [9:0] E_DIV  = S_IF | S_ID | S_EX | F_MEM | D_BUSY;

  typedef struct {
    logic       rst;
    logic       conf;
    logic       dstart;
    logic       ibusy;
    logic       dbusy;
    logic       exc;
    logic [9:0] exp;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  pipe_stall_ctrl #(.DIV_CYCLES(33)) dut (
    .clk            (clk),
    .rst            (rst),
    .conflict_stall (conflict_stall),
    .div_start      (div_start),
    .inst_busy      (inst_busy),
    .data_busy      (data_busy),
    .exc_mem        (exc_mem),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .flush_mem      (flush_mem),
    .flush_wb       (flush_wb),
    .div_busy       (div_busy),
    .div_done       (div_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs at negedge, compare settled outputs before the posedge
  task automatic step(input logic r, input logic c, input logic ds, input logic ib,
                      input logic db, input logic ex, input logic [9:0] exp,
                      input string name);
    logic [9:0] act;
    @(negedge clk);
    rst            = r;
    conflict_stall = c;
    div_start      = ds;
    inst_busy      = ib;
    data_busy      = db;
    exc_mem        = ex;
    #1;
    act = {stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_mem, flush_wb, div_busy, div_done};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    conflict_stall = 1'b0;
    div_start = 1'b0;
    inst_busy = 1'b0;
    data_busy = 1'b0;
    exc_mem = 1'b0;

    //             rst  conf ds   ib   db   exc  expected
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, E_NONE};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_CONF};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_INST};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_INST};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_DATA};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    // exception with a fetch in flight, then the wrong-path fetch is discarded
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_EXC};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_INST};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_INST};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_INST};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_ID};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    // exception under a data stall is deferred until the bus frees
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_DATA};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_DATA};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_DATA};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_EXC};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_EXC};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
    // kill flush is held off by a data stall
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_EXC};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_DATA};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_ID};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE};

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rst, tbl[i].conf, tbl[i].dstart, tbl[i].ibusy, tbl[i].dbusy,
           tbl[i].exc, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Full divide: 33 busy cycles, done on cycle 34, no restart after
    for (int i = 1; i <= 33; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div_busy%0d", i));
    step(0, 0, 1, 0, 0, 0, D_DONE, "div_done");
    step(0, 0, 0, 0, 0, 0, E_NONE, "div_no_restart");
    step(0, 0, 0, 0, 0, 0, E_NONE, "div_idle");

    // Divider reaches DONE under a 4-cycle data stall; div_start still held
    for (int i = 1; i <= 33; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div2_busy%0d", i));
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, 1, 0, E_DATA | D_DONE, $sformatf("done_hold%0d", i));
    step(0, 0, 1, 0, 0, 0, D_DONE, "done_release");
    step(0, 0, 0, 0, 0, 0, E_NONE, "done_idle");

    // Data stall mid-divide: counter keeps running, done still on cycle 34
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div3_pre%0d", i));
    for (int i = 6; i <= 8; i++) step(0, 0, 1, 0, 1, 0, E_DATA, $sformatf("div3_data%0d", i));
    for (int i = 9; i <= 33; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div3_post%0d", i));
    step(0, 0, 1, 0, 0, 0, D_DONE, "div3_done");
    step(0, 0, 0, 0, 0, 0, E_NONE, "div3_idle");

    // Exception mid-divide aborts it; a new div_start restarts from scratch
    for (int i = 1; i <= 10; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div4_pre%0d", i));
    step(0, 0, 1, 0, 0, 1, E_EXC, "div4_exc");
    step(0, 0, 0, 0, 0, 0, E_NONE, "div4_idle");
    for (int i = 1; i <= 33; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div4_re%0d", i));
    step(0, 0, 1, 0, 0, 0, D_DONE, "div4_done");
    step(0, 0, 0, 0, 0, 0, E_NONE, "div4_end");

    // Reset mid-divide with pending exception: clean state, never any div_done
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 0, 0, E_DIV, $sformatf("div5_pre%0d", i));
    step(0, 0, 1, 0, 1, 1, E_DATA, "div5_pend");
    step(1, 0, 1, 0, 0, 0, E_NONE, "rst_mid");
    for (int i = 1; i <= 40; i++) step(0, 0, 0, 0, 0, 0, E_NONE, $sformatf("post_rst%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
